// File: rtl/result_pipe.sv
// Result pipeline + forwarding: carries unit results DEPTH stages to register-file writeback.
// Latency: input at edge N sits in stage k during cycle N+k; writeback during cycle N+DEPTH.
// Backpressure: none; the pipe never stalls, flush only drops the youngest entries.
module result_pipe #(
    parameter int REG_ADDR_WD  = 7,
    parameter int REG_DATA_WD  = 128,
    parameter int DEPTH        = 7,
    parameter int FLUSH_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [REG_ADDR_WD-1:0] in_addr,
    input  logic [REG_DATA_WD-1:0] in_data,
    input  logic [2:0]             in_latency,
    input  logic                   flush,
    input  logic [REG_ADDR_WD-1:0] q_addr,
    output logic                   fwd_hit,
    output logic                   fwd_pend,
    output logic [REG_DATA_WD-1:0] fwd_data,
    output logic                   wb_en,
    output logic [REG_ADDR_WD-1:0] wb_addr,
    output logic [REG_DATA_WD-1:0] wb_data
);

    // Index i holds pipeline stage i+1.
    logic                   stg_vld  [DEPTH];
    logic [REG_ADDR_WD-1:0] stg_addr [DEPTH];
    logic [REG_DATA_WD-1:0] stg_dat  [DEPTH];
    logic [2:0]             stg_lat  [DEPTH];

    logic [2:0] lat_in;

    always_comb begin
        lat_in = in_latency;
        if (in_latency == 3'd0) begin
            lat_in = 3'd1;
        end else if (int'(in_latency) > DEPTH) begin
            lat_in = 3'(DEPTH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_vld[i]  <= 1'b0;
                stg_addr[i] <= '0;
                stg_dat[i]  <= '0;
                stg_lat[i]  <= '0;
            end
        end else begin
            stg_vld[0]  <= in_valid & ~flush;
            stg_addr[0] <= in_addr;
            stg_dat[0]  <= in_data;
            stg_lat[0]  <= lat_in;
            for (int i = 1; i < DEPTH; i++) begin
                // Entries landing in the youngest FLUSH_STAGES stages belong to the killed path.
                stg_vld[i]  <= stg_vld[i-1] & ~(flush & (i < FLUSH_STAGES));
                stg_addr[i] <= stg_addr[i-1];
                stg_dat[i]  <= stg_dat[i-1];
                stg_lat[i]  <= stg_lat[i-1];
            end
        end
    end

    logic                   match_fnd;
    logic                   match_rdy;
    logic [REG_DATA_WD-1:0] match_dat;

    // Scan oldest to youngest so the youngest match overrides; its readiness alone decides.
    always_comb begin
        match_fnd = 1'b0;
        match_rdy = 1'b0;
        match_dat = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stg_vld[i] && (stg_addr[i] == q_addr)) begin
                match_fnd = 1'b1;
                match_rdy = ((i + 1) >= int'(stg_lat[i]));
                match_dat = stg_dat[i];
            end
        end
    end

    assign fwd_hit  = match_fnd & match_rdy;
    assign fwd_pend = match_fnd & ~match_rdy;
    assign fwd_data = (match_fnd && match_rdy) ? match_dat : '0;

    assign wb_en   = stg_vld[DEPTH-1];
    assign wb_addr = stg_vld[DEPTH-1] ? stg_addr[DEPTH-1] : '0;
    assign wb_data = stg_vld[DEPTH-1] ? stg_dat[DEPTH-1] : '0;

endmodule
